fp32_div: RTL and testbench

Sequential IEEE-754 single-precision divider, the inverse operation to `fp32_mul` in the fp32 arithmetic set. It computes `a / b` with a restoring radix-2 mantissa divider (one quotient bit per clock), round-to-nearest-even, and the same special-value and flush-to-zero policy as the multiplier. A start/busy/done handshake lets a controller issue one division at a time.

---
 rtl/fp32_div.sv | 138 +++++++++++++
 tb/tb_fp32_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_div.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2 mantissa
// division (one quotient bit per clock), round-to-nearest-even, flush-to-zero.
module fp32_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [31:0] ZERO32  = 32'h0000_0000;
  localparam logic [31:0] P_INF32 = 32'h7F80_0000;
  localparam logic [31:0] NAN32   = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [25:0]        q;
  logic [24:0]        rem;
  logic [23:0]        mb;
  logic               sign_r;
  logic signed [9:0]  exp_r;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_ab;
  logic        is_special;
  logic [31:0] special_res;
  logic [25:0] trial;
  logic        ge;

  // Normalize the 26-bit quotient, apply RNE, then clamp to inf/zero.
  function automatic logic [31:0] round_pack(input logic [25:0]       qv,
                                             input logic              rem_nz,
                                             input logic              s,
                                             input logic signed [9:0] e_in);
    logic [22:0]       frac;
    logic              guard, sticky, rnd;
    logic signed [9:0] e;
    if (qv[25]) begin
      frac   = qv[24:2];
      guard  = qv[1];
      sticky = qv[0] | rem_nz;
      e      = e_in;
    end else begin
      frac   = qv[23:1];
      guard  = qv[0];
      sticky = rem_nz;
      e      = e_in - 10'sd1;
    end
    rnd = guard & (sticky | frac[0]);
    // An all-ones fraction that rounds up wraps to 1.0 at the next exponent.
    if (rnd & (&frac)) e = e + 10'sd1;
    frac = frac + 23'(rnd);
    if (e >= 10'sd255) return {s, P_INF32[30:0]};
    if (e <= 10'sd0)   return {s, ZERO32[30:0]};
    return {s, e[7:0], frac};
  endfunction

  assign a_zero  = (a[30:23] == 8'h00);
  assign b_zero  = (b[30:23] == 8'h00);
  assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign sign_ab = a[31] ^ b[31];

  always_comb begin
    is_special  = 1'b1;
    special_res = NAN32;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
      special_res = NAN32;
    else if (a_inf | b_zero)
      special_res = {sign_ab, P_INF32[30:0]};
    else if (a_zero | b_inf)
      special_res = {sign_ab, ZERO32[30:0]};
    else
      is_special = 1'b0;
  end

  assign trial = {1'b0, rem} - {2'b00, mb};
  assign ge    = ~trial[25];

  // Datapath: operand capture at the start edge, one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sign_r <= sign_ab;
      exp_r  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
      rem    <= {2'b01, a[22:0]};
      mb     <= {1'b1, b[22:0]};
      q      <= 26'h0;
    end else if (state == CALC) begin
      q   <= {q[24:0], ge};
      rem <= (ge ? trial[24:0] : rem) << 1;
    end
  end

  // Control: handshake, iteration count and the architecturally visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= ZERO32;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_special) begin
              result <= special_res;
              done   <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= 5'd0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= ROUND;
        end
        ROUND: begin
          result <= round_pack(q, |rem, sign_r, exp_r);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: directed cases plus random operands scored
// against an exact long-division reference model.
module tb_fp32_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp32_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact quotient with many extra bits, rounded to nearest-even.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output bit special);
    bit s;
    int ex, ey, e, sh;
    bit xz, yz, xi, yi, xn, yn;
    longint unsigned ma, mb, num, qq, rm, mant, rest, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    special = 1'b1;
    if (xn || yn || (xz && yz) || (xi && yi)) r = 32'h7FC00000;
    else if (xi || yz)                        r = {s, 31'h7F800000};
    else if (xz || yi)                        r = {s, 31'h0};
    else begin
      special = 1'b0;
      ma  = 64'(x[22:0]) | 64'h800000;
      mb  = 64'(y[22:0]) | 64'h800000;
      num = ma << 38;
      qq  = num / mb;
      rm  = num % mb;
      e   = ex - ey + 127;
      if (qq >= (64'd1 << 38)) sh = 15;
      else begin sh = 14; e = e - 1; end
      mant = qq >> sh;
      rest = qq & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rest > half || (rest == half && (rm != 0 || mant[0]))) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
      if (e >= 255)    r = {s, 31'h7F800000};
      else if (e <= 0) r = {s, 31'h0};
      else             r = {s, e[7:0], mant[22:0]};
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Called at #1 after an edge; lat counts edges until done is seen.
  task automatic wait_done(input int max, output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 0; i < max; i++) begin
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat, bc;
    issue(x, y);
    wait_done(60, lat, bc);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bc), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, seen;
    logic [31:0] x, y, rr;
    bit sp;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("basic_6_2",  32'h40C00000, 32'h40000000, 32'h40400000, 27);
    run("round_1_3",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27);
    run("sign_neg",   32'hBF800000, 32'h3F800000, 32'hBF800000, 27);
    run("sp_x_div0",  32'h3F800000, 32'h00000000, 32'h7F800000, 0);
    run("sp_0_div0",  32'h00000000, 32'h00000000, 32'h7FC00000, 0);
    run("sp_inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 0);
    run("sp_nan",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0);
    run("sp_x_inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 0);
    run("overflow",   32'h7F000000, 32'h3E800000, 32'h7F800000, 27);
    run("underflow",  32'h00800000, 32'h4F000000, 32'h00000000, 27);
    run("denorm_in",  32'h00400000, 32'h3F800000, 32'h00000000, 0);

    // start pulsed at cycle 10 of a busy division is ignored
    issue(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, lat, bc);
    check("ignore_lat", 32'(lat), 32'd17);
    check("ignore_res", result, 32'h40400000);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("ignore_no_second_done", 32'(seen), 32'd0);
    check("ignore_res_hold", result, 32'h40400000);

    // start asserted in the done cycle is accepted
    issue(32'h40C00000, 32'h40000000);
    wait_done(60, lat, bc);
    check("b2b_first_res", result, 32'h40400000);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_hold_during_busy", result, 32'h40400000);
    wait_done(60, lat, bc);
    check("b2b_second_lat", 32'(lat), 32'd27);
    check("b2b_second_res", result, 32'h3EAAAAAB);

    // asynchronous reset in the middle of CALC
    issue(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("rst_mid_no_done", 32'(seen), 32'd0);
    run("after_rst_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 27);

    for (int i = 0; i < 120; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 4 != 3) begin
        x[30:23] = 8'($urandom_range(100, 154));
        y[30:23] = 8'($urandom_range(100, 154));
      end
      ref_div(x, y, rr, sp);
      issue(x, y);
      wait_done(60, lat, bc);
      check($sformatf("rand%0d_res_%h_%h", i, x, y), result, rr);
      check($sformatf("rand%0d_lat", i), 32'(lat), sp ? 32'd0 : 32'd27);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
